fetch_pc_sequencer: RTL
=======================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the fetch PC register and consumes the hazard controller's IF-side outputs: i2i stall/flush and load_pc
//  redirect. Each cycle it presents the fetch address to the I-cache, advances it by 4, holds it under stall,
//  or overwrites it on redirect. It also maintains a fetch epoch so downstream logic can discard stale responses.
// PARAMETERS
//  ADDR_WIDTH  32            width of PC / new_pc
//  RESET_PC    32'h0040_0000 first fetch address after reset
//  EPOCH_W     2             width of the fetch epoch counter
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous reset, active low
//  i2i_stall      in   1           hold fetch PC (hazard_control_ifc.stall)
//  i2i_flush      in   1           invalidate the current fetch (hazard_control_ifc.flush)
//  load_pc_we     in   1           redirect request (load_pc_ifc.we)
//  load_pc_new_pc in   ADDR_WIDTH  redirect target (load_pc_ifc.new_pc)
//  fetch_pc       out  ADDR_WIDTH  address presented to the I-cache
//  fetch_valid    out  1           fetch_pc is a live request
//  fetch_epoch    out  EPOCH_W     epoch tag travelling with the request
//  redirect_taken out  1           one-cycle pulse: a redirect was applied at the last edge
// BEHAVIOUR
//  Reset (async, rst_n=0): fetch_pc=RESET_PC, fetch_valid=0, fetch_epoch=0, redirect_taken=0, state=BOOT.
//  FSM states:
//    BOOT   first edge after reset release -> RUN. fetch_valid=1. PC is not advanced on this edge.
//    RUN    no redirect and no stall: fetch_pc += 4 (mod 2^ADDR_WIDTH, wraps silently).
//           stall without redirect -> HOLD. fetch_pc is unchanged.
//    HOLD   fetch_pc is held while i2i_stall=1. Stall drop without redirect -> RUN. fetch_pc advances on the
//           edge where stall is low.
//  Priority at each edge: redirect > stall > advance.
//    load_pc_we=1 in any state except BOOT: fetch_pc<=load_pc_new_pc, fetch_epoch+=1 (wraps),
//    redirect_taken<=1. State -> RUN if i2i_stall=0, otherwise -> HOLD.
//    The redirect is never dropped under stall, because the I-cache does not register missed requests.
//  Redirect in BOOT: applied as above, and the state still exits to RUN/HOLD.
//  fetch_valid: registered. Cleared for one cycle after an edge where i2i_flush=1 and load_pc_we=0.
//    Otherwise 1 in RUN/HOLD.
//  Redirect with flush set (mispredict recovery): fetch_valid stays 1 and the new target is live next cycle.
//  Back-to-back redirects: each one applies, the latest target wins, and the epoch increments once per edge.
//  Latency: a redirect target appears on fetch_pc one cycle after load_pc_we.
//  Unaligned new_pc: stored unmodified. Alignment checking is the I-cache's job.
//  Reset asserted mid-stall or mid-redirect: asynchronously returns to reset values. No pending state survives.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    Adds outputs perf_stall_cycles[31:0], perf_redirects[31:0] and perf_flushes[31:0].
//    Each is a saturating counter, cleared by reset.
//    perf_stall_cycles increments on each cycle with i2i_stall=1 and load_pc_we=0.
//    perf_redirects increments on each applied redirect.
//    perf_flushes increments on each cycle with i2i_flush=1.
//    Under SIMULATION, stats_event("fetch_redirect") is also called per redirect.
//  FETCH_PERF_EN undefined: those ports and counters are absent. Core behaviour is identical.
// STRUCTURE
//  Shared package (mips_core_pkg): fetch_state_e {BOOT, RUN, HOLD}, PC_INC=4, RESET_PC default value.
//  One sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_EN.
//  Its inputs are stall, redirect and flush; its outputs are the three saturating counters.
//  The rest is a single always_ff with the FSM, PC register and epoch, plus an always_comb for next-state.
// TESTING
//  1. Reset release, no hazards for 3 cycles:
//     fetch_pc=0x00400000, 0x00400000, 0x00400004, 0x00400008; fetch_valid 0 then 1; epoch=0.
//  2. In RUN at 0x00400010, i2i_stall=1 for 4 cycles then 0:
//     fetch_pc holds 0x00400010 for 4 cycles, then 0x00400014. perf_stall_cycles=4 with FETCH_PERF_EN.
//  3. While stalled at 0x00400020, load_pc_we=1 with new_pc=0x00400100 for 1 cycle, stall still high:
//     fetch_pc=0x00400100 and held; epoch=1; redirect_taken pulses; state HOLD.
//  4. Mispredict: i2i_flush=1, load_pc_we=1, new_pc=0x00400200 in the same cycle, then one redirect per
//     cycle to 0x300 and 0x400:
//     fetch_valid stays 1; fetch_pc follows 0x200, 0x300, 0x400; epoch advances by 3 with EPOCH_W wrap 3->0.
//  5. Flush without redirect at 0x00400040: fetch_valid=0 for one cycle; fetch_pc advances to 0x00400044.
//  6. fetch_pc=0xFFFFFFFC in RUN -> next 0x00000000.
//     Assert rst_n=0 mid-HOLD -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared fetch-side types and constants for the MIPS core.
// SIMULATION builds also get the stats_event hook used by the fetch perf counters.
package mips_core_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

`ifdef SIMULATION
  // Hook for the simulation statistics collector; intentionally inert here.
  function automatic void stats_event(input string name);
    string unused_name;
    unused_name = name;
  endfunction
`endif

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch-side event counters (stall cycles, redirects, flushes).
// Instantiated by fetch_pc_sequencer only when FETCH_PERF_EN is defined.
module fetch_perf_counters
  import mips_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic        flush,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_flushes
);

  logic [31:0] stall_cnt_q, redirect_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (stall && stall_cnt_q != '1)       stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (redirect && redirect_cnt_q != '1) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (flush && flush_cnt_q != '1)       flush_cnt_q    <= flush_cnt_q + 32'd1;
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (rst_n && redirect) stats_event("fetch_redirect");
  end
`endif

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_redirects    = redirect_cnt_q;
  assign perf_flushes      = flush_cnt_q;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register and epoch: advances, holds under stall, or takes a redirect (redirect wins).
// Define FETCH_PERF_EN to add saturating stall/redirect/flush counters on extra outputs.
module fetch_pc_sequencer
  import mips_core_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned           EPOCH_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2i_stall,
  input  logic                  i2i_flush,
  input  logic                  load_pc_we,
  input  logic [ADDR_WIDTH-1:0] load_pc_new_pc,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_valid,
  output logic [EPOCH_W-1:0]    fetch_epoch,
  output logic                  redirect_taken
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_redirects,
  output logic [31:0]           perf_flushes
`endif
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [EPOCH_W-1:0]    epoch_q, epoch_d;
  logic                  valid_q, valid_d;
  logic                  redirect_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    // The I-cache keeps no record of missed requests, so a redirect is never held off by stall.
    if (load_pc_we) begin
      pc_d    = load_pc_new_pc;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (state_q != BOOT && !i2i_stall) begin
      pc_d = pc_q + ADDR_WIDTH'(PC_INC);
    end
    if (state_q == BOOT && !load_pc_we) begin
      state_d = RUN;
    end else begin
      state_d = i2i_stall ? HOLD : RUN;
    end
    valid_d = !(i2i_flush && !load_pc_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      epoch_q    <= '0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      valid_q    <= valid_d;
      redirect_q <= load_pc_we;
    end
  end

  assign fetch_pc       = pc_q;
  assign fetch_valid    = valid_q;
  assign fetch_epoch    = epoch_q;
  assign redirect_taken = redirect_q;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (i2i_stall && !load_pc_we),
    .redirect          (load_pc_we),
    .flush             (i2i_flush),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects),
    .perf_flushes      (perf_flushes)
  );
`endif

endmodule
